// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and FSM state type for the matrix readback block
package matrix_pkg;

  localparam int MATRIX_WIDTH = 10;
  localparam int SYNC_STAGES  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/matrix_readback_if.sv
// rtl/matrix_readback_if.sv - Raspberry Pi GPIO link: strobe, shift clock and status lines
interface matrix_readback_if;

  logic rpi_latch;
  logic rpi_sclk;
  logic rpi_sdo;
  logic rpi_busy;
  logic rpi_irq;

  modport slave (
    input  rpi_latch,
    input  rpi_sclk,
    output rpi_sdo,
    output rpi_busy,
    output rpi_irq
  );

  modport master (
    output rpi_latch,
    output rpi_sclk,
    input  rpi_sdo,
    input  rpi_busy,
    input  rpi_irq
  );

endinterface

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - multi-stage synchronizer with registered rising-edge pulse
module gpio_sync #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] stg [DEPTH];
  logic [W-1:0] prev;

  // The rise pulse is registered so a strobe reaches the FSM DEPTH+1 edges after it toggles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      prev <= '0;
      rise <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      prev <= stg[DEPTH-1];
      rise <= stg[DEPTH-1] & ~prev;
    end
  end

  assign sync = stg[DEPTH-1];

endmodule

// File: rtl/matrix_readback.sv
// rtl/matrix_readback.sv - snapshots matrix return lines and shifts them plus parity to a Raspberry Pi
module matrix_readback #(
  parameter int WIDTH       = matrix_pkg::MATRIX_WIDTH,
  parameter int SYNC_STAGES = matrix_pkg::SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  matrix_in,
  matrix_readback_if.slave  rpi
);

  import matrix_pkg::*;

  localparam int CW = $clog2(WIDTH + 2);

  logic [WIDTH-1:0] matrix_sync, matrix_rise;
  logic             latch_sync, latch_rise;
  logic             sclk_sync, sclk_rise;
  logic             unused_sync;

  state_t           state, state_n;
  logic [WIDTH-1:0] snap, snap_n;
  logic             par, par_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0]    nxt_cnt;
  logic             sdo, sdo_n;
  logic             irq, irq_n;

  gpio_sync #(.W(WIDTH), .DEPTH(SYNC_STAGES)) u_matrix_sync (
    .clk   (clk),
    .reset (reset),
    .din   (matrix_in),
    .sync  (matrix_sync),
    .rise  (matrix_rise)
  );

  gpio_sync #(.W(1), .DEPTH(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rpi.rpi_latch),
    .sync  (latch_sync),
    .rise  (latch_rise)
  );

  gpio_sync #(.W(1), .DEPTH(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rpi.rpi_sclk),
    .sync  (sclk_sync),
    .rise  (sclk_rise)
  );

  assign unused_sync = ^{matrix_rise, latch_sync, sclk_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      sdo     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      snap    <= snap_n;
      par     <= par_n;
      bit_cnt <= bit_cnt_n;
      sdo     <= sdo_n;
      irq     <= irq_n;
    end
  end

  assign nxt_cnt = bit_cnt + CW'(1);

  always_comb begin
    state_n   = state;
    snap_n    = snap;
    par_n     = par;
    bit_cnt_n = bit_cnt;
    sdo_n     = sdo;
    irq_n     = irq;

    // A latch rise always wins, in either state, and swallows any coincident sclk rise.
    if (latch_rise) begin
      state_n   = SHIFT;
      snap_n    = matrix_sync;
      par_n     = ^matrix_sync;
      bit_cnt_n = '0;
      sdo_n     = matrix_sync[WIDTH-1];
    end else if (state == SHIFT && sclk_rise) begin
      bit_cnt_n = nxt_cnt;
      if (bit_cnt == CW'(WIDTH)) begin
        state_n = IDLE;
        sdo_n   = 1'b0;
      end else if (nxt_cnt == CW'(WIDTH)) begin
        sdo_n = par;
      end else begin
        sdo_n = snap[CW'(WIDTH - 1) - nxt_cnt];
      end
    end

    if (latch_rise) begin
      irq_n = 1'b0;
    end else if (state == IDLE && matrix_sync != snap) begin
      irq_n = 1'b1;
    end
  end

  assign rpi.rpi_sdo  = sdo;
  assign rpi.rpi_busy = (state == SHIFT);
  assign rpi.rpi_irq  = irq;

endmodule

// File: doc/matrix_readback.md
MATRIX_READBACK -- requirements
Module: matrix_readback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the number of matrix return lines.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for every asynchronous input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port matrix_in, input, WIDTH bits: asynchronous return lines from the matrix under test.
REQ-006 The block SHALL have port rpi_latch, input, 1 bit: asynchronous Raspberry Pi GPIO strobe that requests a snapshot.
REQ-007 The block SHALL have port rpi_sclk, input, 1 bit: asynchronous Raspberry Pi GPIO shift clock.
REQ-008 The block SHALL have port rpi_sdo, output, 1 bit: serial data to the Raspberry Pi.
REQ-009 The block SHALL have port rpi_busy, output, 1 bit: high while a frame is being shifted.
REQ-010 The block SHALL have port rpi_irq, output, 1 bit: synchronized matrix_in differs from the last snapshot.

Function
REQ-011 matrix_in, rpi_latch and rpi_sclk SHALL each pass through a SYNC_STAGES flop synchronizer before any use.
REQ-012 A rising edge SHALL be a one-cycle pulse: the synchronized value is 1 and the previous synchronized value was 0.
REQ-013 The FSM SHALL have two states, IDLE and SHIFT; the reset state is IDLE.
REQ-014 In IDLE, a latch rise SHALL do all of the following on the next clk edge: capture the synchronized matrix_in into snap, compute par = XOR of snap (even parity), clear bit_cnt, drive rpi_sdo = snap[WIDTH-1], enter SHIFT.
REQ-015 The frame SHALL be WIDTH+1 bits: snap MSB first, then par.
REQ-016 In SHIFT, each sclk rise SHALL advance to the next frame bit on rpi_sdo and increment bit_cnt.
REQ-017 On the sclk rise that advances past par (the WIDTH+1th rise), the block SHALL enter IDLE and drive rpi_sdo = 0.
REQ-018 bit_cnt SHALL be $clog2(WIDTH+2) bits wide and SHALL never exceed WIDTH+1.
REQ-019 A latch rise in SHIFT SHALL abort the current frame and restart per REQ-014 with a fresh snapshot.
REQ-020 Simultaneous latch rise and sclk rise SHALL be treated as a latch rise; the sclk rise is dropped.
REQ-021 An sclk rise in IDLE SHALL be ignored; rpi_sdo stays 0.
REQ-022 rpi_busy SHALL equal (state == SHIFT).
REQ-023 rpi_irq SHALL be set on any cycle where synchronized matrix_in != snap while in IDLE.
REQ-024 rpi_irq SHALL be cleared by a latch rise; when clear and set occur in the same cycle, clear wins, and re-evaluation happens the next cycle against the new snap.
REQ-025 Latency from rpi_latch rising at a clk edge to rpi_sdo valid SHALL be SYNC_STAGES+2 clk cycles (4 with default parameters).
REQ-026 The Raspberry Pi SHALL hold each sclk level for at least SYNC_STAGES+2 clk cycles and sample rpi_sdo before each sclk rise; the block guarantees nothing for faster sclk.

Reset
REQ-027 While reset is high, the block SHALL hold: state=IDLE, snap=0, par=0, bit_cnt=0, rpi_sdo=0, rpi_busy=0, rpi_irq=0, and all synchronizer and edge flops at 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clk edge.
REQ-029 After reset deasserts, an input already high SHALL produce one rise (flops start at 0); for rpi_latch this starts a frame.

Structure
REQ-030 Shared package matrix_pkg SHALL hold: MATRIX_WIDTH=10, SYNC_STAGES=2, and the state enum {IDLE, SHIFT}.
REQ-031 Sub-module gpio_sync (parameterised width and depth, with rise output) SHALL be instantiated for matrix_in, rpi_latch and rpi_sclk.

Verification
REQ-032 Scenario: matrix_in=0x2C3, latch pulse, 11 sclk pulses -> rpi_sdo bits 1,0,1,1,0,0,0,0,1,1,1; rpi_busy falls after the 11th rise.
REQ-033 Scenario: matrix_in=0x000, latch pulse -> frame of 11 zeros; rpi_irq=0 throughout.
REQ-034 Scenario: after 5 sclk rises, new latch with matrix_in=0x3FF -> frame restarts, rpi_sdo=1 for 10 bits, par=0.
REQ-035 Scenario: latch and sclk rise in the same cycle -> bit_cnt=0 and rpi_sdo=snap[9].
REQ-036 Scenario: in IDLE with snap=0x2C3, matrix_in changes to 0x2C2 -> rpi_irq=1 within 3 cycles; the next latch clears it.
REQ-037 Scenario: reset asserted at bit 6 -> rpi_sdo=0, rpi_busy=0, rpi_irq=0 without a clk edge; the next latch yields a full 11-bit frame.
